// File: rtl/neighbour_count_gen.sv
// -----------------------------------------------------------------------------
// neighbour_count_gen
//
// Purpose:
//   Takes a snapshot of the placed mine map, then walks the active dim x dim
//   board one cell per clock. For every cell it counts the mines among its
//   in-bounds neighbours (0..8) and writes that count into an internal map.
//   A registered random-access read port serves the draw and reveal logic.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   start           - one-cycle request to snapshot and compute
//   dimension_size  - active board edge, legal range 1..MAX_DIM
//   mine_array      - mine map indexed [x][y], 1 = mine
//   rd_x, rd_y      - read address
//   rd_count        - registered neighbour count of (rd_x, rd_y)
//   rd_mine         - registered snapshot mine bit of (rd_x, rd_y)
//   busy            - high during LOAD and SCAN
//   done            - level, high from scan completion until the next start
//
// Optional feature (macro NEIGHBOUR_TOTAL_EN):
//   mines_expected  - expected mine count inside the active area
//   mine_total      - mines counted inside the active area during SCAN
//   mine_mismatch   - set with done when mine_total != mines_expected
// -----------------------------------------------------------------------------
module neighbour_count_gen #(
  parameter int MAX_DIM = 16,
  parameter int CNT_W   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [4:0]                        dimension_size,
  input  logic [MAX_DIM-1:0][MAX_DIM-1:0]   mine_array,
  input  logic [3:0]                        rd_x,
  input  logic [3:0]                        rd_y,
  output logic [CNT_W-1:0]                  rd_count,
  output logic                              rd_mine,
  output logic                              busy,
  output logic                              done
`ifdef NEIGHBOUR_TOTAL_EN
  ,
  input  logic [5:0]                        mines_expected,
  output logic [8:0]                        mine_total,
  output logic                              mine_mismatch
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t                                  state_q;
  logic [MAX_DIM-1:0][MAX_DIM-1:0]         snap_q;
  logic [MAX_DIM-1:0][MAX_DIM-1:0][CNT_W-1:0] cnt_q;
  logic [4:0]                              dim_q;
  logic [3:0]                              x_q;
  logic [3:0]                              y_q;
  logic                                    busy_q;
  logic                                    done_q;
  logic [CNT_W-1:0]                        rd_count_q;
  logic                                    rd_mine_q;

  logic [CNT_W-1:0]                        nbr_sum_d;
  logic [4:0]                              nbr_px;
  logic [4:0]                              nbr_py;
  logic [3:0]                              nbr_ix;
  logic [3:0]                              nbr_iy;
  logic                                    dim_ok;
  logic                                    last_cell;
  logic                                    rd_in_range;

`ifdef NEIGHBOUR_TOTAL_EN
  logic [8:0]                              total_q;
  logic [8:0]                              total_d;
  logic                                    mismatch_q;
`endif

  assign dim_ok      = (dimension_size != 5'd0) && (dimension_size <= 5'(MAX_DIM));
  assign last_cell   = ({1'b0, x_q} == dim_q - 5'd1) && ({1'b0, y_q} == dim_q - 5'd1);
  assign rd_in_range = ({1'b0, rd_x} < dim_q) && ({1'b0, rd_y} < dim_q);

`ifdef NEIGHBOUR_TOTAL_EN
  assign total_d = total_q + 9'(snap_q[x_q][y_q]);
`endif

  // Neighbour sum for the current scan cell. Coordinates are offset by +1
  // (px = x+dx+1) so the -1 neighbour stays unsigned and is rejected by
  // px==0 instead of wrapping to the far edge.
  always_comb begin
    nbr_sum_d = '0;
    nbr_px    = '0;
    nbr_py    = '0;
    nbr_ix    = '0;
    nbr_iy    = '0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        if (!(dx == 1 && dy == 1)) begin
          nbr_px = {1'b0, x_q} + 5'(dx);
          nbr_py = {1'b0, y_q} + 5'(dy);
          nbr_ix = 4'(nbr_px - 5'd1);
          nbr_iy = 4'(nbr_py - 5'd1);
          if (nbr_px != 5'd0 && nbr_py != 5'd0 && nbr_px <= dim_q && nbr_py <= dim_q) begin
            nbr_sum_d = nbr_sum_d + CNT_W'(snap_q[nbr_ix][nbr_iy]);
          end
        end
      end
    end
  end

  // Control FSM, snapshot, count map and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      cnt_q      <= '0;
      dim_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_count_q <= '0;
      rd_mine_q  <= 1'b0;
`ifdef NEIGHBOUR_TOTAL_EN
      total_q    <= '0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      // Reads outside the active board return zero even if the snapshot
      // holds a mine there.
      rd_count_q <= rd_in_range ? cnt_q[rd_x][rd_y] : '0;
      rd_mine_q  <= rd_in_range ? snap_q[rd_x][rd_y] : 1'b0;

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (dim_ok) begin
              state_q <= LOAD;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              // Illegal size: finish immediately with an empty board.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              snap_q  <= '0;
              cnt_q   <= '0;
              dim_q   <= '0;
`ifdef NEIGHBOUR_TOTAL_EN
              total_q    <= '0;
              mismatch_q <= (mines_expected != 6'd0);
`endif
            end
          end
        end

        LOAD: begin
          snap_q  <= mine_array;
          dim_q   <= dimension_size;
          cnt_q   <= '0;
          x_q     <= '0;
          y_q     <= '0;
          state_q <= SCAN;
`ifdef NEIGHBOUR_TOTAL_EN
          total_q    <= '0;
          mismatch_q <= 1'b0;
`endif
        end

        SCAN: begin
          cnt_q[x_q][y_q] <= nbr_sum_d;
`ifdef NEIGHBOUR_TOTAL_EN
          total_q <= total_d;
`endif
          if (last_cell) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef NEIGHBOUR_TOTAL_EN
            mismatch_q <= (total_d != 9'(mines_expected));
`endif
          end else if ({1'b0, x_q} == dim_q - 5'd1) begin
            x_q <= '0;
            y_q <= y_q + 4'd1;
          end else begin
            x_q <= x_q + 4'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_count = rd_count_q;
  assign rd_mine  = rd_mine_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef NEIGHBOUR_TOTAL_EN
  assign mine_total    = total_q;
  assign mine_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_neighbour_count_gen.sv
// -----------------------------------------------------------------------------
// tb_neighbour_count_gen
//
// Purpose:
//   Directed bench for neighbour_count_gen. Read expectations live in a table
//   of hand-computed {scenario, x, y, count, mine} records; timing, reset and
//   ignored-start corners are covered by short hand-written sequences.
//   With NEIGHBOUR_TOTAL_EN defined the mine total/mismatch outputs are
//   exercised as well.
// -----------------------------------------------------------------------------
module tb_neighbour_count_gen;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        dimSize;
  logic [15:0][15:0] mineArray;
  logic [3:0]        rdX;
  logic [3:0]        rdY;
  logic [3:0]        rdCount;
  logic              rdMine;
  logic              busy;
  logic              done;
`ifdef NEIGHBOUR_TOTAL_EN
  logic [5:0]        minesExpected;
  logic [8:0]        mineTotal;
  logic              mineMismatch;
`endif

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    int         scen;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] cnt;
    logic       mine;
  } readVec_t;

  readVec_t vecs[$];

  neighbour_count_gen #(.MAX_DIM(16), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .dimension_size (dimSize),
    .mine_array     (mineArray),
    .rd_x           (rdX),
    .rd_y           (rdY),
    .rd_count       (rdCount),
    .rd_mine        (rdMine),
    .busy           (busy),
    .done           (done)
`ifdef NEIGHBOUR_TOTAL_EN
    ,
    .mines_expected (minesExpected),
    .mine_total     (mineTotal),
    .mine_mismatch  (mineMismatch)
`endif
  );

  always #5 clk = ~clk;

  // One clock, then settle so outputs are sampled away from the edge.
  task tick();
    @(posedge clk);
    #1;
  endtask

  task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present inputs with a one-cycle start pulse; returns just after the
  // edge that sampled start.
  task applyStimulus(input logic [4:0] dim, input logic [15:0][15:0] mines);
    dimSize   = dim;
    mineArray = mines;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Start a run and check busy during the scan plus the done latency,
  // measured in edges after the start-sampling edge.
  task runAndTime(input string name, input logic [4:0] dim, input logic [15:0][15:0] mines);
    int n;
    int d;
    bit busyGap;
    d = int'(dim);
    applyStimulus(dim, mines);
    checkOutput($sformatf("%s busy after start", name), busy, 1);
    checkOutput($sformatf("%s done after start", name), done, 0);
    n = 0;
    busyGap = 1'b0;
    while (!done && n < 400) begin
      tick();
      n++;
      if (!done && !busy) busyGap = 1'b1;
    end
    checkOutput($sformatf("%s done latency", name), n, d * d + 1);
    checkOutput($sformatf("%s busy gap", name), busyGap, 0);
    checkOutput($sformatf("%s busy at done", name), busy, 0);
  endtask

  task readCell(input logic [3:0] x, input logic [3:0] y, output logic [3:0] cnt, output logic mine);
    rdX = x;
    rdY = y;
    tick();
    cnt  = rdCount;
    mine = rdMine;
  endtask

  task applyReads(input int scen, input string name);
    logic [3:0] c;
    logic       m;
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen) begin
        readCell(vecs[i].x, vecs[i].y, c, m);
        checkOutput($sformatf("%s rd_count(%0d,%0d)", name, vecs[i].x, vecs[i].y), c, vecs[i].cnt);
        checkOutput($sformatf("%s rd_mine(%0d,%0d)", name, vecs[i].x, vecs[i].y), m, vecs[i].mine);
      end
    end
  endtask

  task addVec(input int scen, input int x, input int y, input int cnt, input int mine);
    readVec_t v;
    v.scen = scen;
    v.x    = 4'(x);
    v.y    = 4'(y);
    v.cnt  = 4'(cnt);
    v.mine = 1'(mine);
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0][15:0] single;
    logic [15:0][15:0] corners;
    logic [15:0][15:0] full;
    logic [15:0][15:0] rightBand;
    logic [3:0]        c;
    logic              m;
    int                n;

    // Scenario 1: single mine at [3][3], dim 8
    addVec(1, 2, 2, 1, 0); addVec(1, 3, 2, 1, 0); addVec(1, 4, 2, 1, 0);
    addVec(1, 2, 3, 1, 0); addVec(1, 3, 3, 0, 1); addVec(1, 4, 3, 1, 0);
    addVec(1, 2, 4, 1, 0); addVec(1, 3, 4, 1, 0); addVec(1, 4, 4, 1, 0);
    addVec(1, 1, 3, 0, 0); addVec(1, 5, 3, 0, 0); addVec(1, 3, 5, 0, 0);
    addVec(1, 0, 0, 0, 0); addVec(1, 7, 7, 0, 0);
    // Scenario 2: mines at [0][0], [0][1], [1][0], [7][7], dim 8
    addVec(2, 1, 1, 3, 0); addVec(2, 0, 0, 2, 1); addVec(2, 0, 1, 2, 1);
    addVec(2, 1, 0, 2, 1); addVec(2, 7, 7, 0, 1); addVec(2, 6, 6, 1, 0);
    addVec(2, 2, 0, 1, 0); addVec(2, 0, 2, 1, 0); addVec(2, 2, 2, 0, 0);
    addVec(2, 0, 7, 0, 0); addVec(2, 7, 0, 0, 0);
    // Scenario 3: all mines, dim 16
    addVec(3, 5, 5, 8, 1);  addVec(3, 0, 5, 5, 1);  addVec(3, 15, 15, 3, 1);
    addVec(3, 0, 0, 3, 1);  addVec(3, 15, 0, 3, 1); addVec(3, 7, 15, 5, 1);
    addVec(3, 15, 8, 5, 1);
    // Scenario 4: dim 10, mines only at x >= 10
    addVec(4, 9, 9, 0, 0);  addVec(4, 9, 5, 0, 0);  addVec(4, 0, 0, 0, 0);
    addVec(4, 9, 0, 0, 0);  addVec(4, 12, 2, 0, 0); addVec(4, 5, 12, 0, 0);
    addVec(4, 10, 10, 0, 0); addVec(4, 15, 15, 0, 0);

    single = '0;
    single[3][3] = 1'b1;
    corners = '0;
    corners[0][0] = 1'b1;
    corners[0][1] = 1'b1;
    corners[1][0] = 1'b1;
    corners[7][7] = 1'b1;
    full = '1;
    rightBand = '0;
    for (int x = 10; x < 16; x++) rightBand[x] = 16'hFFFF;

    rst       = 1'b1;
    start     = 1'b0;
    dimSize   = 5'd0;
    mineArray = '0;
    rdX       = '0;
    rdY       = '0;
`ifdef NEIGHBOUR_TOTAL_EN
    minesExpected = '0;
`endif

    // Reset state
    repeat (3) tick();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset rd_count", rdCount, 0);
    checkOutput("reset rd_mine", rdMine, 0);
    rst = 1'b0;
    tick();
    readCell(4'd0, 4'd0, c, m);
    checkOutput("idle rd_count", c, 0);
    checkOutput("idle rd_mine", m, 0);

    // Illegal size goes straight to DONE with an empty board
    applyStimulus(5'd17, full);
    checkOutput("bad dim done", done, 1);
    checkOutput("bad dim busy", busy, 0);
    readCell(4'd5, 4'd5, c, m);
    checkOutput("bad dim rd_count", c, 0);
    checkOutput("bad dim rd_mine", m, 0);

    runAndTime("single", 5'd8, single);
    applyReads(1, "single");

    runAndTime("corners", 5'd8, corners);
    applyReads(2, "corners");

    runAndTime("full16", 5'd16, full);
    applyReads(3, "full16");

    runAndTime("dim10", 5'd10, rightBand);
    applyReads(4, "dim10");

    // Reset 20 cycles into SCAN aborts without a done
    applyStimulus(5'd8, single);
    repeat (21) tick();
    checkOutput("pre-abort busy", busy, 1);
    rst = 1'b1;
    tick();
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort rd_count", rdCount, 0);
    checkOutput("abort rd_mine", rdMine, 0);
    rst = 1'b0;
    readCell(4'd2, 4'd2, c, m);
    checkOutput("post-abort rd_count", c, 0);
    readCell(4'd3, 4'd3, c, m);
    checkOutput("post-abort rd_mine", m, 0);
    runAndTime("restart", 5'd8, single);
    applyReads(1, "restart");

    // start pulsed mid-scan with different inputs is ignored
    applyStimulus(5'd8, single);
    n = 0;
    while (!done && n < 400) begin
      if (n == 10) begin
        start     = 1'b1;
        dimSize   = 5'd16;
        mineArray = full;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    checkOutput("ignored start done latency", n, 65);
    applyReads(1, "ignored start");

`ifdef NEIGHBOUR_TOTAL_EN
    begin
      logic [15:0][15:0] ten;
      ten = '0;
      ten[0][0] = 1'b1; ten[1][2] = 1'b1; ten[2][4] = 1'b1; ten[3][6] = 1'b1;
      ten[4][1] = 1'b1; ten[5][3] = 1'b1; ten[6][5] = 1'b1; ten[7][7] = 1'b1;
      ten[7][0] = 1'b1; ten[0][7] = 1'b1;
      // Outside the 8x8 area, must not be totalled
      ten[9][0] = 1'b1; ten[0][9] = 1'b1; ten[8][8] = 1'b1;
      minesExpected = 6'd10;
      runAndTime("total10", 5'd8, ten);
      checkOutput("total10 mine_total", mineTotal, 10);
      checkOutput("total10 mine_mismatch", mineMismatch, 0);
      minesExpected = 6'd9;
      runAndTime("total9", 5'd8, ten);
      checkOutput("total9 mine_total", mineTotal, 10);
      checkOutput("total9 mine_mismatch", mineMismatch, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/neighbour_count_gen.md
Name: neighbour_count_gen

Overview:
- Downstream consumer of the mine placement stage.
- Snapshots the 2D mine array after placement completes, then scans the active board one cell per clock. For each cell it computes the number of mines among its 8 in-bounds neighbours (0..8) and stores the result in an internal 4-bit count map.
- Exposes a registered random-access read port, used by the board draw logic and by the reveal/flood logic.

Parameters:
- MAX_DIM, 16, maximum board edge in cells; sizes the snapshot and count map (MAX_DIM x MAX_DIM).
- CNT_W, 4, width of each stored neighbour count; must hold 0..8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to snapshot and compute
- dimension_size  input  5  active board edge (8, 10 or 16; any 1..MAX_DIM legal)
- mine_array  input  [MAX_DIM-1:0][MAX_DIM-1:0]  mine map indexed [x][y], '1 = mine
- rd_x  input  4  read column
- rd_y  input  4  read row
- rd_count  output  CNT_W  neighbour count of (rd_x, rd_y), registered
- rd_mine  output  1  mine bit of (rd_x, rd_y) from snapshot, registered
- busy  output  1  high during LOAD and SCAN
- done  output  1  level; high from scan completion until next accepted start

Behaviour:
- Reset:
  - Reset is rst, synchronous, active-high, on clock clk.
  - All outputs go to 0; state goes to IDLE.
  - Snapshot and count map are cleared to 0.
  - Reset asserted mid-SCAN aborts immediately with no partial done.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE:
  - start=1 with dimension_size in 1..MAX_DIM goes to LOAD.
  - start=1 with dimension_size=0 or >MAX_DIM goes directly to DONE, with an empty map (all counts 0).
- LOAD (1 cycle):
  - Capture mine_array and dimension_size into internal registers.
  - Clear the count map.
  - Reset scan indices to x=0, y=0.
  - Go to SCAN.
- SCAN:
  - Processes one cell per cycle, x inner (0..dim-1) and y outer.
  - count = sum of snapshot[x+dx][y+dy] for dx,dy in {-1,0,1}, excluding (0,0).
  - A neighbour is counted only if 0 <= x+dx < dim and 0 <= y+dy < dim. No wrap-around across edges.
  - Edge cells use unsigned compare against dim; index -1 is never wrapped to MAX_DIM-1.
  - Mine cells also receive their neighbour count; the count is stored regardless of the cell's own bit.
  - After cell (dim-1, dim-1), go to DONE.
- DONE: done=1, busy=0. start=1 re-enters LOAD (done drops on the next cycle).
- Timing: with start sampled at cycle T:
  - busy=1 at T+1..T+1+dim².
  - done=1 at T+2+dim².
  - Example: dim=8 gives done at T+66; dim=16 gives done at T+258.
- start while busy is ignored. Inputs mine_array and dimension_size may change after LOAD without effect.
- Read port:
  - rd_count and rd_mine update one cycle after rd_x/rd_y are presented.
  - Reads are valid at any time; during SCAN they return the partially written map.
  - rd_x >= dim or rd_y >= dim returns rd_count=0, rd_mine=0.
- Arithmetic: neighbour sum is 4 bits wide; maximum 8, so no saturation is needed.

Optional Feature:
- Macro: NEIGHBOUR_TOTAL_EN.
- When defined:
  - Adds input mines_expected[5:0].
  - Adds output mine_total[8:0], the number of '1 cells inside the active dim x dim area, accumulated during SCAN. It is reset to 0 in LOAD and valid when done=1.
  - Adds output mine_mismatch, set with done when mine_total != mines_expected and cleared in LOAD.
- When undefined: those ports and the accumulator are absent; all other behaviour is identical.

Test Plan:
- Single mine at [3][3], dim=8, start at T:
  - done rises at T+66.
  - Cells (2..4, 2..4) except (3,3) read 1.
  - (3,3) reads 0 with rd_mine=1.
  - All other cells read 0.
- Corner mines at [0][0], [0][1], [1][0], dim=8:
  - (1,1) reads 3.
  - (0,0) reads 2.
  - (7,7) reads 0.
  - A mine at [7][7] does not affect (0,0), confirming no wrap.
- Full 16x16 array of '1, dim=16:
  - Interior (5,5) reads 8, edge (0,5) reads 5, corner (15,15) reads 3.
  - done at T+258.
- dim=10 with mines placed only at x>=10:
  - All in-range reads return 0.
  - Read (12,2) returns 0/0.
- Reset asserted 20 cycles into SCAN:
  - Next cycle busy=0, done=0, all reads 0.
  - A new start completes normally.
- start pulsed during SCAN is ignored, and done timing is unchanged.
- With NEIGHBOUR_TOTAL_EN defined, 10 mines, mines_expected=10:
  - mine_total=10, mine_mismatch=0.
  - With mines_expected=9: mine_mismatch=1.
